// File: rtl/fetch_seq_if.sv
// Instruction-memory request/response bus between the fetch sequencer and memory.
interface fetch_seq_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: single outstanding fetch, redirect with drain of an
// in-flight request, misaligned-target trap to TRAP_VEC.
module fetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    fetch_seq_if.master imem,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        core_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        trap,
    output logic [31:0] trap_addr
);

    typedef enum logic [1:0] {IDLE, FETCH, VALID, DRAIN} state_t;

    state_t      state, state_d;
    logic [31:0] pc, pc_d;
    logic [31:0] addr_q, addr_d;
    logic        req_q, req_d;
    logic        valid_d;
    logic [31:0] instr_d, ipc_d;
    logic        trap_d;
    logic [31:0] taddr_d;
    logic        acked;
    logic        misaligned;
    logic [31:0] target;

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign acked          = req_q & imem.imem_ack;
    assign misaligned     = (redirect_pc[1:0] != 2'b00);
    assign target         = misaligned ? TRAP_VEC : redirect_pc;

    always_comb begin
        state_d = state;
        pc_d    = pc;
        req_d   = req_q;
        addr_d  = addr_q;
        valid_d = instr_valid;
        instr_d = instr;
        ipc_d   = instr_pc;
        trap_d  = 1'b0;
        taddr_d = trap_addr;

        if (redirect_valid && misaligned) begin
            trap_d  = 1'b1;
            taddr_d = redirect_pc;
        end

        unique case (state)
            IDLE: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
                state_d = FETCH;
                if (redirect_valid) pc_d = target;
            end
            FETCH: begin
                if (!req_q) begin
                    // No request in flight yet, so a redirect simply retargets the one about to issue.
                    req_d  = 1'b1;
                    addr_d = redirect_valid ? target : pc;
                    if (redirect_valid) pc_d = target;
                end else if (redirect_valid) begin
                    pc_d = target;
                    if (acked) req_d = 1'b0;
                    else       state_d = DRAIN;
                end else if (acked) begin
                    req_d   = 1'b0;
                    instr_d = imem.imem_rdata;
                    ipc_d   = pc;
                    pc_d    = pc + 32'd4;
                    valid_d = 1'b1;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (redirect_valid) begin
                    pc_d    = target;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end else if (core_ready) begin
                    valid_d = 1'b0;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (redirect_valid) pc_d = target;
                if (acked) begin
                    req_d   = 1'b0;
                    state_d = FETCH;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            req_q       <= 1'b0;
            addr_q      <= RESET_PC;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            trap        <= 1'b0;
            trap_addr   <= '0;
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            instr_valid <= valid_d;
            instr       <= instr_d;
            instr_pc    <= ipc_d;
            trap        <= trap_d;
            trap_addr   <= taddr_d;
        end
    end

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: directed cycle table, then random traffic against a
// program-order reference model of the delivered instruction stream.
module tb_fetch_seq;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
    localparam logic [31:0] BAD      = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr, instr_pc;
    logic        core_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap;
    logic [31:0] trap_addr;

    fetch_seq_if bus ();

    fetch_seq #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem           (bus),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .core_ready     (core_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap           (trap),
        .trap_addr      (trap_addr)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    typedef struct {
        logic        rst, ack;
        logic [31:0] rdata;
        logic        ready, rv;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_ipc, e_instr;
        logic        e_trap;
        logic [31:0] e_taddr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic r, input logic a, input logic [31:0] d, input logic rdy,
                               input logic rv, input logic [31:0] rpc, input logic er,
                               input logic [31:0] ea, input logic ev, input logic [31:0] eip,
                               input logic [31:0] ei, input logic et, input logic [31:0] eta);
        vec_t x;
        x.rst = r; x.ack = a; x.rdata = d; x.ready = rdy; x.rv = rv; x.rpc = rpc;
        x.e_req = er; x.e_addr = ea; x.e_valid = ev; x.e_ipc = eip; x.e_instr = ei;
        x.e_trap = et; x.e_taddr = eta;
        return x;
    endfunction

    initial begin
        logic        p_req, p_valid;
        logic [31:0] p_addr, p_ipc, p_instr;
        logic [31:0] exp_pc, exp_taddr;
        logic        exp_trap;
        int          dly, deliveries;

        rst = 1'b0; core_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        bus.imem_ack = 1'b0; bus.imem_rdata = '0;

        // rst ack rdata rdy rv rpc | req addr valid ipc instr trap taddr
        vecs.push_back(v(0,0,0,0,0,0,            0,RESET_PC,0,0,0,0,0));
        vecs.push_back(v(0,0,0,0,0,0,            0,RESET_PC,0,0,0,0,0));
        vecs.push_back(v(1,0,0,0,0,0,            0,0,0,0,0,0,0));
        vecs.push_back(v(1,0,0,0,0,0,            1,32'h0,0,0,0,0,0));
        vecs.push_back(v(1,1,32'hA000_0000,1,0,0, 0,0,1,32'h0,32'hA000_0000,0,0));
        vecs.push_back(v(1,0,0,1,0,0,            0,0,0,0,0,0,0));
        vecs.push_back(v(1,0,0,0,0,0,            1,32'h4,0,0,0,0,0));
        vecs.push_back(v(1,1,32'hA000_0001,1,0,0, 0,0,1,32'h4,32'hA000_0001,0,0));
        vecs.push_back(v(1,0,0,1,0,0,            0,0,0,0,0,0,0));
        vecs.push_back(v(1,0,0,0,0,0,            1,32'h8,0,0,0,0,0));
        vecs.push_back(v(1,0,0,0,1,32'h200,      1,32'h8,0,0,0,0,0));
        vecs.push_back(v(1,0,0,0,0,0,            1,32'h8,0,0,0,0,0));
        vecs.push_back(v(1,1,BAD,0,0,0,          0,0,0,0,0,0,0));
        vecs.push_back(v(1,0,0,0,0,0,            1,32'h200,0,0,0,0,0));
        vecs.push_back(v(1,1,32'hA000_0003,0,0,0, 0,0,1,32'h200,32'hA000_0003,0,0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(v(1,0,0,0,0,0,        0,0,1,32'h200,32'hA000_0003,0,0));
        vecs.push_back(v(1,0,0,1,1,32'h202,      0,0,0,0,0,1,32'h202));
        vecs.push_back(v(1,0,0,0,0,0,            1,TRAP_VEC,0,0,0,0,32'h202));
        vecs.push_back(v(1,1,32'hA000_0004,0,0,0, 0,0,1,TRAP_VEC,32'hA000_0004,0,32'h202));
        vecs.push_back(v(1,0,0,0,1,32'hFFFF_FFFC, 0,0,0,0,0,0,32'h202));
        vecs.push_back(v(1,0,0,0,0,0,            1,32'hFFFF_FFFC,0,0,0,0,32'h202));
        vecs.push_back(v(1,1,32'hA000_0005,0,0,0, 0,0,1,32'hFFFF_FFFC,32'hA000_0005,0,32'h202));
        vecs.push_back(v(1,0,0,1,0,0,            0,0,0,0,0,0,32'h202));
        vecs.push_back(v(1,0,0,0,0,0,            1,32'h0,0,0,0,0,32'h202));
        vecs.push_back(v(1,0,0,0,1,32'h300,      1,32'h0,0,0,0,0,32'h202));
        vecs.push_back(v(0,0,0,0,0,0,            0,RESET_PC,0,0,0,0,0));
        vecs.push_back(v(1,0,0,0,0,0,            0,0,0,0,0,0,0));
        vecs.push_back(v(1,0,0,0,0,0,            1,RESET_PC,0,0,0,0,0));
        vecs.push_back(v(1,1,BAD,0,1,32'h400,    0,0,0,0,0,0,0));
        vecs.push_back(v(1,0,0,0,0,0,            1,32'h400,0,0,0,0,0));
        vecs.push_back(v(1,1,32'hA000_0006,0,0,0, 0,0,1,32'h400,32'hA000_0006,0,0));
        vecs.push_back(v(1,0,0,1,0,0,            0,0,0,0,0,0,0));
        vecs.push_back(v(1,0,0,0,0,0,            1,32'h404,0,0,0,0,0));
        vecs.push_back(v(1,0,0,0,1,32'h500,      1,32'h404,0,0,0,0,0));
        vecs.push_back(v(1,1,BAD,0,1,32'h600,    0,0,0,0,0,0,0));
        vecs.push_back(v(1,0,0,0,0,0,            1,32'h600,0,0,0,0,0));
        vecs.push_back(v(1,1,32'hA000_0007,0,0,0, 0,0,1,32'h600,32'hA000_0007,0,0));
        vecs.push_back(v(0,0,0,0,0,0,            0,RESET_PC,0,0,0,0,0));
        vecs.push_back(v(1,0,0,0,1,32'h700,      0,0,0,0,0,0,0));
        vecs.push_back(v(1,0,0,0,0,0,            1,32'h700,0,0,0,0,0));

        foreach (vecs[k]) begin
            @(negedge clk);
            rst = vecs[k].rst; bus.imem_ack = vecs[k].ack; bus.imem_rdata = vecs[k].rdata;
            core_ready = vecs[k].ready; redirect_valid = vecs[k].rv; redirect_pc = vecs[k].rpc;
            @(posedge clk); #1;
            chk($sformatf("v%0d.req", k), 32'(bus.imem_req), 32'(vecs[k].e_req));
            if (vecs[k].e_req || !vecs[k].rst)
                chk($sformatf("v%0d.addr", k), bus.imem_addr, vecs[k].e_addr);
            chk($sformatf("v%0d.valid", k), 32'(instr_valid), 32'(vecs[k].e_valid));
            if (vecs[k].e_valid || !vecs[k].rst) begin
                chk($sformatf("v%0d.ipc", k), instr_pc, vecs[k].e_ipc);
                chk($sformatf("v%0d.instr", k), instr, vecs[k].e_instr);
            end
            chk($sformatf("v%0d.trap", k), 32'(trap), 32'(vecs[k].e_trap));
            chk($sformatf("v%0d.taddr", k), trap_addr, vecs[k].e_taddr);
        end

        // Random phase: fresh reset, memory with random ack latency, random core stalls and redirects.
        @(negedge clk);
        rst = 1'b0; bus.imem_ack = 1'b0; core_ready = 1'b0; redirect_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_pc = RESET_PC; exp_taddr = '0; exp_trap = 1'b0;
        dly = $urandom_range(0, 3); deliveries = 0;

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            p_req = bus.imem_req; p_addr = bus.imem_addr; p_valid = instr_valid;
            p_ipc = instr_pc; p_instr = instr;
            if (bus.imem_ack) begin
                bus.imem_ack = 1'b0;
            end else if (bus.imem_req) begin
                if (dly == 0) begin
                    bus.imem_ack   = 1'b1;
                    bus.imem_rdata = mem_word(bus.imem_addr);
                    dly = $urandom_range(0, 3);
                end else begin
                    dly--;
                end
            end
            core_ready     = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0: redirect_pc = 32'($urandom_range(0, 1023)) << 2;
                1: redirect_pc = (32'($urandom_range(0, 1023)) << 2) | 32'($urandom_range(1, 3));
                2: redirect_pc = 32'hFFFF_FFF8;
                default: redirect_pc = 32'hFFFF_FFFC;
            endcase
            @(posedge clk); #1;

            if (p_valid && core_ready && !redirect_valid) begin
                chk("rnd.ipc", p_ipc, exp_pc);
                chk("rnd.instr", p_instr, mem_word(p_ipc));
                exp_pc = exp_pc + 32'd4;
                deliveries++;
            end
            exp_trap = 1'b0;
            if (redirect_valid) begin
                if (redirect_pc[1:0] == 2'b00) begin
                    exp_pc = redirect_pc;
                end else begin
                    exp_pc    = TRAP_VEC;
                    exp_trap  = 1'b1;
                    exp_taddr = redirect_pc;
                end
            end
            chk("rnd.trap", 32'(trap), 32'(exp_trap));
            chk("rnd.taddr", trap_addr, exp_taddr);
            if (p_req && !bus.imem_ack) begin
                chk("rnd.req_hold", 32'(bus.imem_req), 32'd1);
                chk("rnd.addr_hold", bus.imem_addr, p_addr);
            end
        end
        chk("rnd.progress", 32'(deliveries >= 50), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
